// File: rtl/multi_ctrl_fork_fifo_pkg.sv
// Shared definitions for the two-lane multicast fork FIFO.
// Holds the pointer/count width helper and the depth legality check.
package multi_ctrl_fork_fifo_pkg;

    // Number of bits needed to index 'value' distinct states (minimum 1).
    function automatic int clog2_w(input int value);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) < value) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

    // Lane depth must be a power of two so pointers wrap by plain overflow.
    function automatic bit is_pow2(input int value);
        return (value >= 32'sd2) && ((value & (value - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/multi_ctrl_fork_fifo_if.sv
// Handshake bundle between the upstream multicast pipe, the fork and its
// two consumers. 'master' is the environment side, 'slave' is the fork.
interface multi_ctrl_fork_fifo_if
    import multi_ctrl_fork_fifo_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = clog2_w(DEPTH + 32'sd1);

    logic [1:0]        s_valid_in;
    logic [DATA_W-1:0] s_data_in;
    logic [1:0]        s_ready_out;
    logic              m0_valid_out;
    logic [DATA_W-1:0] m0_data_out;
    logic              m0_ready_in;
    logic              m1_valid_out;
    logic [DATA_W-1:0] m1_data_out;
    logic              m1_ready_in;
    logic [CNT_W-1:0]  m0_count;
    logic [CNT_W-1:0]  m1_count;

    modport master (
        output s_valid_in, s_data_in, m0_ready_in, m1_ready_in,
        input  s_ready_out, m0_valid_out, m0_data_out, m1_valid_out,
               m1_data_out, m0_count, m1_count
    );

    modport slave (
        input  s_valid_in, s_data_in, m0_ready_in, m1_ready_in,
        output s_ready_out, m0_valid_out, m0_data_out, m1_valid_out,
               m1_data_out, m0_count, m1_count
    );
endinterface

// File: rtl/multi_ctrl_lane_fifo.sv
// Single-lane FIFO: registered pointers, count and full/empty flags.
// Storage is not reset; the head is presented straight from storage.
module multi_ctrl_lane_fifo
    import multi_ctrl_fork_fifo_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 4,
    localparam int PTR_W = clog2_w(DEPTH),
    localparam int CNT_W = clog2_w(DEPTH + 32'sd1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              push_eff_s;
    logic              pop_eff_s;

    // Next-state for pointers, occupancy, flags and storage write.
    always_comb begin
        push_eff_s = push & ~full_q;
        pop_eff_s  = pop & ~empty_q;
        wr_ptr_d   = push_eff_s ? (wr_ptr_q + PTR_W'(1'b1)) : wr_ptr_q;
        rd_ptr_d   = pop_eff_s ? (rd_ptr_q + PTR_W'(1'b1)) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push_eff_s) - CNT_W'(pop_eff_s);
        empty_d    = (count_d == CNT_W'(1'b0));
        full_d     = (count_d == CNT_W'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (push_eff_s && (wr_ptr_q == PTR_W'(i))) ? push_data : mem_q[i];
        end
    end

    // Data storage, deliberately without reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state; an asynchronous reset discards all queued entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
endmodule

// File: rtl/multi_ctrl_fork_fifo.sv
// Two-lane multicast fork: one shared input beat is written atomically into
// every targeted lane FIFO; each lane drains to its own consumer.
module multi_ctrl_fork_fifo
    import multi_ctrl_fork_fifo_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multi_ctrl_fork_fifo_if.slave  bus
);
    localparam int CNT_W = clog2_w(DEPTH + 32'sd1);

    if (!is_pow2(DEPTH)) begin : g_depth_illegal
        $error("multi_ctrl_fork_fifo: DEPTH must be a power of two and at least 2");
    end

    logic              ready_s;
    logic              push0_s, push1_s;
    logic              pop0_s, pop1_s;
    logic              empty0_s, empty1_s;
    logic              full0_s, full1_s;
    logic [DATA_W-1:0] head0_s, head1_s;
    logic [CNT_W-1:0]  count0_s, count1_s;

    // Ready/valid glue: input is accepted only when neither lane is full,
    // so a multicast beat is never split; full flags are registered.
    always_comb begin
        ready_s = ~full0_s & ~full1_s;
        push0_s = bus.s_valid_in[0] & ready_s;
        push1_s = bus.s_valid_in[1] & ready_s;
        pop0_s  = ~empty0_s & bus.m0_ready_in;
        pop1_s  = ~empty1_s & bus.m1_ready_in;
    end

    multi_ctrl_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0_s),
        .push_data (bus.s_data_in),
        .pop       (pop0_s),
        .head_data (head0_s),
        .empty     (empty0_s),
        .full      (full0_s),
        .count     (count0_s)
    );

    multi_ctrl_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1_s),
        .push_data (bus.s_data_in),
        .pop       (pop1_s),
        .head_data (head1_s),
        .empty     (empty1_s),
        .full      (full1_s),
        .count     (count1_s)
    );

    assign bus.s_ready_out  = {2{ready_s}};
    assign bus.m0_valid_out = ~empty0_s;
    assign bus.m0_data_out  = head0_s;
    assign bus.m0_count     = count0_s;
    assign bus.m1_valid_out = ~empty1_s;
    assign bus.m1_data_out  = head1_s;
    assign bus.m1_count     = count1_s;
endmodule

// File: doc/multi_ctrl_fork_fifo.md
# multi_ctrl_fork_fifo

Fork stage that consumes a two-lane multicast stream and fans it out to two independent consumers. The stream has a 2-bit per-lane valid and one shared data bus. The block sits directly downstream of the two-lane backward-registered pipe stage. Each lane has its own small FIFO, so a slow consumer stalls only its own lane until the FIFOs fill. Input acceptance is atomic across lanes, so one multicast beat is never split over two cycles.

## Interface
- DATA_W, 256, width of the shared data bus and of each output data bus
- DEPTH, 4, entries per lane FIFO; power of two, at least 2
- clk  input  1  clock, all state updates on its rising edge
- rst_n  input  1  reset, asynchronous, active-low
- s_valid_in  input  2  per-lane valid from upstream; bit i means "beat targets lane i"
- s_data_in  input  DATA_W  shared data for all asserted lanes
- s_ready_out  output  2  per-lane ready to upstream; both bits always equal
- m0_valid_out  output  1  lane 0 FIFO head valid
- m0_data_out  output  DATA_W  lane 0 FIFO head data
- m0_ready_in  input  1  lane 0 consumer ready
- m1_valid_out  output  1  lane 1 FIFO head valid
- m1_data_out  output  DATA_W  lane 1 FIFO head data
- m1_ready_in  input  1  lane 1 consumer ready
- m0_count  output  clog2(DEPTH+1)  lane 0 occupancy
- m1_count  output  clog2(DEPTH+1)  lane 1 occupancy

## Operation
- Ready rule: s_ready_out = {2{~full0 & ~full1}}. Full flags are registered state, so there is no combinational path from m*_ready_in to s_ready_out.
- Push rule: lane i pushes s_data_in when s_valid_in[i] & s_ready_out[i].
  - s_valid_in = 2'b11 pushes the same data into both FIFOs in the same cycle.
  - s_valid_in = 2'b00 pushes nothing.
- Pop rule: lane i pops when m_i_valid_out & m_i_ready_in.
  - m_i_valid_out = ~empty_i.
  - m_i_data_out is the head entry.
- Each lane keeps a write pointer, a read pointer and a count.
  - Pointer width is log2(DEPTH). Pointers wrap modulo DEPTH.
  - count_next = count + push - pop.
  - full = (count == DEPTH); empty = (count == 0).
- Simultaneous push and pop on one lane: both take effect and the count is unchanged.
  - This is legal at any occupancy below DEPTH.
  - When full, push is already blocked by the ready rule, so the pop alone proceeds.
- Empty lane: there is no bypass. A beat pushed into an empty FIFO is presented on the cycle after the push.
- A lane that is full blocks both lanes at the input, including beats with s_valid_in = 2'b01 or 2'b10 that target only the non-full lane.
- Data storage is not reset. Pointers, counts and flags are reset.
- Reset values:
  - s_ready_out = 2'b11
  - m0_valid_out = m1_valid_out = 0
  - m0_count = m1_count = 0
  - m*_data_out is undefined (X allowed) while the lane is empty.
- Reset asserted mid-operation: all queued entries are discarded immediately (asynchronous). Outputs take reset values within the same cycle.

## Timing
- Latency from input acceptance to output valid is 1 cycle.
- Sustained throughput is 1 beat/cycle per lane when both consumers hold ready high.
- A lane reaching DEPTH entries deasserts s_ready_out on the next cycle.
  - Because full is registered, the push that fills the FIFO is itself accepted.
- A pop from a full lane reasserts s_ready_out on the next cycle. Full-to-full turnaround therefore costs one bubble.
- Upstream holds s_data_in and s_valid_in stable while ready is low. The block does not check this.

## Structure
- Shared package holds:
  - a clog2-style pointer/count width function
  - a DEPTH power-of-two legality check used in an initial assertion
- One sub-module is natural: multi_ctrl_lane_fifo.
  - Parameters: DATA_W, DEPTH.
  - Ports: push, push_data, pop, head_data, empty, full, count.
  - The top instantiates it twice and adds the ready/valid glue.

## Test plan
- Reset release, then s_valid_in = 2'b11 with data 0xA5 for one cycle, both consumers ready -> next cycle both m*_valid_out = 1 with data 0xA5, then empty; counts go 0→1→0.
- Lane 0 consumer held not-ready, stream of 2'b11 beats 1,2,3,4 -> m0_count reaches 4, s_ready_out = 2'b00 from the following cycle, lane 1 drains 1..4 in order. Raise m0_ready_in -> ready returns 1 cycle after the first pop, lane 0 drains 1..4.
- Alternating s_valid_in 2'b01/2'b10 with data 10,11,12,13 -> lane 0 outputs 10,12; lane 1 outputs 11,13; no duplication.
- Lane 1 at count 3, simultaneous push and pop on lane 1 for 5 cycles -> m1_count stays 3, FIFO order preserved across pointer wrap.
- rst_n pulsed low with both lanes holding 2 entries -> valids drop to 0 and counts to 0 immediately. After release, the first new beat appears alone with no stale data.
- Random valid/ready stress for 10k cycles against a per-lane scoreboard -> no loss, duplication or reordering; s_ready_out bits always equal.
